// File: rtl/apb_fifo_pkg.sv
// Shared types and helpers for the parametrised APB request FIFO.
package apb_fifo_pkg;

    // Widths of the default (legacy 8x32) entry layout.
    localparam int ENTRY_ADDR_W = 32;
    localparam int ENTRY_DATA_W = 32;

    // One buffered APB request as produced by the interconnect arbiter.
    typedef struct packed {
        logic                    write;
        logic [ENTRY_ADDR_W-1:0] addr;
        logic [ENTRY_DATA_W-1:0] wdata;
    } apb_fifo_entry_t;

    // Bits needed to hold an occupancy value in the range 0..depth.
    function automatic int clog2_cnt(input int depth);
        int w;
        w = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << w) <= 64'(depth)) begin
                w = w + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/apb_fifo_ptr_ctrl.sv
// Pointer, occupancy and status-flag control for the APB request FIFO.
// Accept decisions are made from the registered pre-edge flags; a pop on a
// full FIFO frees the slot that a simultaneous push then reuses.
module apb_fifo_ptr_ctrl
    import apb_fifo_pkg::*;
#(
    parameter  int DEPTH     = 8,
    parameter  int AFULL_TH  = DEPTH - 2,
    parameter  int AEMPTY_TH = 2,
    localparam int PTR_W     = $clog2(DEPTH),
    localparam int CNT_W     = clog2_cnt(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_in,
    input  logic             pop_in,
    output logic             push_acc,
    output logic             pop_acc,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty
);

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_TH);
    localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_TH);

    logic [CNT_W-1:0] count_next;

    assign pop_acc  = pop_in && !empty;
    assign push_acc = push_in && (!full || pop_acc);

    // Next occupancy: a simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_next = count;
        if (push_acc && !pop_acc) begin
            count_next = count + CNT_W'(1);
        end else if (!push_acc && pop_acc) begin
            count_next = count - CNT_W'(1);
        end
    end

    // Pointers advance on accepted transfers and wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_acc) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_acc) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Occupancy and flags are registered from count_next so they never glitch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            count        <= count_next;
            full         <= (count_next == DEPTH_C);
            empty        <= (count_next == '0);
            almost_full  <= (count_next >= AFULL_C);
            almost_empty <= (count_next <= AEMPTY_C);
        end
    end

endmodule

// File: rtl/apb_slave_fifo_param.sv
// Parametrised APB request FIFO between the interconnect arbiter (push side)
// and the APB slave driver (pop side). Holds the entry storage, the registered
// pop outputs and the sticky overflow/underflow flags.
module apb_slave_fifo_param
    import apb_fifo_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int DEPTH     = 8,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_in,
    input  logic                       push_write_in,
    input  logic [ADDR_W-1:0]          push_addr_in,
    input  logic [DATA_W-1:0]          push_wdata_in,
    output logic                       data_in_ack,
    input  logic                       pop_in,
    output logic                       pop_valid_out,
    output logic                       pop_write_out,
    output logic [ADDR_W-1:0]          pop_addr_out,
    output logic [DATA_W-1:0]          pop_wdata_out,
    output logic                       full_o,
    output logic                       empty_o,
    output logic                       almost_full_o,
    output logic                       almost_empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       overflow_o,
    output logic                       underflow_o,
    input  logic                       clr_err_in
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = clog2_cnt(DEPTH);

    // Entry layout at this instance's widths.
    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } entry_t;

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("apb_slave_fifo_param: DEPTH must be a power of 2 and at least 2");
    end
    if (AEMPTY_TH >= AFULL_TH) begin : g_bad_thresholds
        $error("apb_slave_fifo_param: AEMPTY_TH must be below AFULL_TH");
    end

    logic             push_acc;
    logic             pop_acc;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    entry_t           mem [DEPTH];
    entry_t           pop_entry;
    logic             push_rej;
    logic             pop_rej;

    apb_fifo_ptr_ctrl #(
        .DEPTH     (DEPTH),
        .AFULL_TH  (AFULL_TH),
        .AEMPTY_TH (AEMPTY_TH)
    ) u_ptr_ctrl (
        .clk          (clk),
        .reset        (reset),
        .push_in      (push_in),
        .pop_in       (pop_in),
        .push_acc     (push_acc),
        .pop_acc      (pop_acc),
        .wr_ptr       (wr_ptr),
        .rd_ptr       (rd_ptr),
        .count        (count),
        .full         (full_o),
        .empty        (empty_o),
        .almost_full  (almost_full_o),
        .almost_empty (almost_empty_o)
    );

    assign count_o  = count;
    assign push_rej = push_in && !push_acc;
    assign pop_rej  = pop_in && !pop_acc;

    // Storage write; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem[wr_ptr] <= '{write: push_write_in, addr: push_addr_in, wdata: push_wdata_in};
        end
    end

    // Pop output registers: one-cycle read latency, hold until the next pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pop_entry     <= '0;
            pop_valid_out <= 1'b0;
        end else begin
            pop_valid_out <= pop_acc;
            if (pop_acc) begin
                pop_entry <= mem[rd_ptr];
            end
        end
    end

    assign pop_write_out = pop_entry.write;
    assign pop_addr_out  = pop_entry.addr;
    assign pop_wdata_out = pop_entry.wdata;

    // Push acknowledge pulse and sticky error flags (a new error beats clear).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_in_ack <= 1'b0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            data_in_ack <= push_acc;
            if (push_rej) begin
                overflow_o <= 1'b1;
            end else if (clr_err_in) begin
                overflow_o <= 1'b0;
            end
            if (pop_rej) begin
                underflow_o <= 1'b1;
            end else if (clr_err_in) begin
                underflow_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_apb_slave_fifo_param.sv
// Scoreboard bench for apb_slave_fifo_param: a queue-based reference model
// predicts per-cycle status and popped entries; a negedge monitor compares.
module tb_apb_slave_fifo_param;

    localparam int DEPTH = 8;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
    } ent_t;

    typedef struct packed {
        logic       ack;
        logic       vld;
        logic [3:0] cnt;
        logic       full;
        logic       empty;
        logic       afull;
        logic       aempty;
        logic       ovf;
        logic       unf;
    } stat_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        push_in = 1'b0;
    logic        push_write_in = 1'b0;
    logic [31:0] push_addr_in = '0;
    logic [31:0] push_wdata_in = '0;
    logic        data_in_ack;
    logic        pop_in = 1'b0;
    logic        pop_valid_out;
    logic        pop_write_out;
    logic [31:0] pop_addr_out;
    logic [31:0] pop_wdata_out;
    logic        full_o;
    logic        empty_o;
    logic        almost_full_o;
    logic        almost_empty_o;
    logic [3:0]  count_o;
    logic        overflow_o;
    logic        underflow_o;
    logic        clr_err_in = 1'b0;

    int checks = 0;
    int fails  = 0;

    ent_t  mq[$];
    ent_t  exp_pop[$];
    stat_t stat_q[$];
    bit    m_ovf = 1'b0;
    bit    m_unf = 1'b0;

    apb_slave_fifo_param #(
        .DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .AFULL_TH(6), .AEMPTY_TH(2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .push_in        (push_in),
        .push_write_in  (push_write_in),
        .push_addr_in   (push_addr_in),
        .push_wdata_in  (push_wdata_in),
        .data_in_ack    (data_in_ack),
        .pop_in         (pop_in),
        .pop_valid_out  (pop_valid_out),
        .pop_write_out  (pop_write_out),
        .pop_addr_out   (pop_addr_out),
        .pop_wdata_out  (pop_wdata_out),
        .full_o         (full_o),
        .empty_o        (empty_o),
        .almost_full_o  (almost_full_o),
        .almost_empty_o (almost_empty_o),
        .count_o        (count_o),
        .overflow_o     (overflow_o),
        .underflow_o    (underflow_o),
        .clr_err_in     (clr_err_in)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one cycle of stimulus (called at posedge+1) and predict its outcome.
    task automatic step(input bit push, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input bit pop, input bit clr);
        int    sz;
        bit    pa;
        bit    pu;
        stat_t r;
        push_in       = push;
        push_write_in = wr;
        push_addr_in  = a;
        push_wdata_in = d;
        pop_in        = pop;
        clr_err_in    = clr;
        sz = mq.size();
        pa = pop && (sz > 0);
        pu = push && ((sz < DEPTH) || pa);
        if (pa) exp_pop.push_back(mq.pop_front());
        if (pu) mq.push_back('{write: wr, addr: a, wdata: d});
        m_ovf = (push && !pu) ? 1'b1 : (clr ? 1'b0 : m_ovf);
        m_unf = (pop && !pa) ? 1'b1 : (clr ? 1'b0 : m_unf);
        r.ack    = pu;
        r.vld    = pa;
        r.cnt    = 4'(mq.size());
        r.full   = (mq.size() == DEPTH);
        r.empty  = (mq.size() == 0);
        r.afull  = (mq.size() >= 6);
        r.aempty = (mq.size() <= 2);
        r.ovf    = m_ovf;
        r.unf    = m_unf;
        @(posedge clk);
        stat_q.push_back(r);
        #1;
        push_in    = 1'b0;
        pop_in     = 1'b0;
        clr_err_in = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_count"}, 64'(count_o), 64'd0);
        chk({tag, "_empty"}, 64'(empty_o), 64'd1);
        chk({tag, "_aempty"}, 64'(almost_empty_o), 64'd1);
        chk({tag, "_full"}, 64'(full_o), 64'd0);
        chk({tag, "_afull"}, 64'(almost_full_o), 64'd0);
        chk({tag, "_ack"}, 64'(data_in_ack), 64'd0);
        chk({tag, "_vld"}, 64'(pop_valid_out), 64'd0);
        chk({tag, "_popdata"}, {pop_wdata_out, pop_addr_out}, 64'd0);
        chk({tag, "_popwr"}, 64'(pop_write_out), 64'd0);
        chk({tag, "_errs"}, 64'({overflow_o, underflow_o}), 64'd0);
    endtask

    // Monitor: per-cycle status compare, and popped-entry compare on valid.
    always @(negedge clk) begin : monitor
        stat_t r;
        ent_t  e;
        if (stat_q.size() > 0) begin
            r = stat_q.pop_front();
            chk("ack", 64'(data_in_ack), 64'(r.ack));
            chk("pop_valid", 64'(pop_valid_out), 64'(r.vld));
            chk("count", 64'(count_o), 64'(r.cnt));
            chk("flags", 64'({full_o, empty_o, almost_full_o, almost_empty_o}),
                64'({r.full, r.empty, r.afull, r.aempty}));
            chk("errs", 64'({overflow_o, underflow_o}), 64'({r.ovf, r.unf}));
        end
        if (pop_valid_out) begin
            if (exp_pop.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_pop: got wdata %0h expected no pop", pop_wdata_out);
            end else begin
                e = exp_pop.pop_front();
                chk("pop_wdata", 64'(pop_wdata_out), 64'(e.wdata));
                chk("pop_addr", 64'(pop_addr_out), 64'(e.addr));
                chk("pop_write", 64'(pop_write_out), 64'(e.write));
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        chk_reset_state("reset");

        // Fill to full.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 32'(i * 4), 32'(i * 10), 1'b0, 1'b0);
        // Push while full, then clear the overflow flag.
        step(1'b1, 1'b1, 32'h100, 32'd999, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        // Pop-on-full with simultaneous push.
        step(1'b1, 1'b0, 32'h200, 32'h55, 1'b1, 1'b0);
        // Drain, then one extra pop to underflow.
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        // Continuous streaming from empty; pointers wrap.
        for (int i = 0; i < 20; i++)
            step(1'b1, i[0], 32'h1000 + 32'(i * 4), 32'hA000 + 32'(i), i > 0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        // Randomised traffic including overflow, underflow and clears.
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 99) < 55, 1'($urandom), $urandom, $urandom,
                 $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 5);
        // Drain, then refill to five entries before a mid-burst reset.
        for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 32'h300 + 32'(i), 32'hB0 + 32'(i), 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'h0, 32'h0, 1'b1, 1'b0);
        #5;
        reset = 1'b0;
        #1;
        chk_reset_state("midreset");
        mq.delete();
        exp_pop.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        // Only post-reset data may come out.
        step(1'b1, 1'b0, 32'hC0, 32'hC0DE, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'hC4, 32'hC1DE, 1'b1, 1'b0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("status_queue_drained", 64'(stat_q.size()), 64'd0);
        chk("pop_queue_drained", 64'(exp_pop.size()), 64'd0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
